des_round_sequencer: RTL and testbench

- Iterative DES round controller: owns the L/R half-block registers and the 56-bit C/D key state.
- Drives one shared f-function datapath (expansion, key mix, S-boxes, P) once per cycle for 16 rounds.
- Sits between the IP/PC-1 front end and the FP back end, with valid/ready handshakes on both sides.
- Handles encrypt and decrypt key-rotation schedules.

---
 rtl/des_round_sequencer_if.sv | 22 ++
 rtl/des_round_sequencer.sv | 97 +++++++++
 tb/tb_des_round_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/des_round_sequencer_if.sv
// Handshake bundle between the IP/PC-1 front end, the round sequencer and the FP back end.
// The sequencer takes the slave side; whoever feeds blocks and drains results takes the master side.
interface des_round_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic [55:0] in_key_cd;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;

    modport master (
        output in_valid, in_block, in_key_cd, in_decrypt, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key_cd, in_decrypt, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: holds L/R and the C/D key state, steps one shared
// f-function datapath through 16 Feistel rounds, encrypt or decrypt key schedule.
module des_round_sequencer #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    des_round_sequencer_if.slave  bus,
    output logic [31:0]           f_r,
    output logic [55:0]           f_cd,
    input  logic [31:0]           f_result,
    output logic                  busy,
    output logic [3:0]            round
);

    localparam int CW = $clog2(NUM_ROUNDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CW-1:0] LAST   = CW'(NUM_ROUNDS - 1);
    localparam logic [CW-1:0] PENULT = CW'(NUM_ROUNDS - 2);

    logic [1:0]    state;
    logic [31:0]   l;
    logic [31:0]   r;
    logic [55:0]   cd;
    logic [CW-1:0] cnt;
    logic          dec;
    logic          singleStep;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // The upcoming round (cnt+2, 1-based) shifts by one only for rounds 2, 9 and 16.
    assign singleStep = (cnt == '0) || (cnt == CW'(7)) || (cnt == PENULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            l     <= '0;
            r     <= '0;
            cd    <= '0;
            cnt   <= '0;
            dec   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        l     <= bus.in_block[63:32];
                        r     <= bus.in_block[31:0];
                        dec   <= bus.in_decrypt;
                        cnt   <= '0;
                        // Decrypt round 1 uses K16, which is the unrotated key.
                        cd    <= bus.in_decrypt ? bus.in_key_cd
                                                : {rotl(bus.in_key_cd[55:28], 1'b0),
                                                   rotl(bus.in_key_cd[27:0], 1'b0)};
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    l   <= r;
                    r   <= l ^ f_result;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end else if (dec) begin
                        cd <= {rotr(cd[55:28], !singleStep), rotr(cd[27:0], !singleStep)};
                    end else begin
                        cd <= {rotl(cd[55:28], !singleStep), rotl(cd[27:0], !singleStep)};
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_block = (state == S_DONE) ? {r, l} : 64'd0;
    assign busy          = (state != S_IDLE);
    assign round         = (state == S_ROUND) ? 4'(cnt) : 4'd0;
    assign f_r           = r;
    assign f_cd          = cd;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Randomized bench for des_round_sequencer against a Feistel reference model whose
// round keys come straight from the cumulative DES shift table.
module tb_des_round_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] f_r;
   logic [55:0] f_cd;
   logic [31:0] f_result;
   logic        busy;
   logic [3:0]  round;
   logic        zeroF = 1'b0;

   int total = 0;
   int bad = 0;

   // Cumulative left shift of C/D seen by encrypt round n+1.
   int encCum[16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

   logic [55:0] expKey[16];
   logic [31:0] expR[16];
   logic [63:0] expOut;
   logic [63:0] lastOut;

   always #5 clk = ~clk;

   des_round_sequencer_if bus();

   des_round_sequencer #(.NUM_ROUNDS(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .f_r      (f_r),
      .f_cd     (f_cd),
      .f_result (f_result),
      .busy     (busy),
      .round    (round)
   );

   // Stand-in for the f datapath: any nonlinear function of R and the round key will do.
   function automatic logic [31:0] toyF(input logic [31:0] rv, input logic [55:0] k);
      logic [31:0] t;
      t = rv ^ k[31:0] ^ {k[55:32], 8'h5A};
      t = t * 32'h9E3779B1;
      return t ^ (t >> 13) ^ {k[27:0], 4'h3};
   endfunction

   assign f_result = zeroF ? 32'd0 : toyF(f_r, f_cd);

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
      logic [55:0] t;
      t = {x, x} << s;
      return t[55:28];
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int s);
      return rotl28(x, 28 - s);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Decrypt round n uses the encrypt key of round 17-n.
   task automatic buildReference(input logic [63:0] blk, input logic [55:0] key,
                                 input logic dec, input logic zf);
      logic [31:0] lv, rv, nr;
      int s;
      lv = blk[63:32];
      rv = blk[31:0];
      for (int n = 0; n < 16; n++) begin
         if (!dec) begin
            s = encCum[n];
            expKey[n] = {rotl28(key[55:28], s), rotl28(key[27:0], s)};
         end else begin
            s = 28 - encCum[15 - n];
            expKey[n] = {rotr28(key[55:28], s), rotr28(key[27:0], s)};
         end
         expR[n] = rv;
         nr = lv ^ (zf ? 32'd0 : toyF(rv, expKey[n]));
         lv = rv;
         rv = nr;
      end
      expOut = {rv, lv};
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic applyStimulus(input logic [63:0] blk, input logic [55:0] key, input logic dec,
                                input int hold, input logic noise);
      buildReference(blk, key, dec, zeroF);
      bus.in_valid   = 1'b1;
      bus.in_block   = blk;
      bus.in_key_cd  = key;
      bus.in_decrypt = dec;
      bus.out_ready  = 1'b0;
      checkOutput("in_ready_idle", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         bus.in_decrypt = ~dec;
         if (noise) begin
            bus.in_valid  = 1'($urandom);
            bus.in_block  = {$urandom, $urandom};
            bus.in_key_cd = {$urandom, $urandom};
            bus.out_ready = 1'($urandom);
         end else begin
            bus.in_valid = 1'b0;
         end
         checkOutput("round_idx", 64'(round), 64'(n));
         checkOutput("f_r", 64'(f_r), 64'(expR[n]));
         checkOutput("f_cd", 64'(f_cd), 64'(expKey[n]));
         checkOutput("busy_round", 64'(busy), 64'd1);
         checkOutput("in_ready_round", 64'(bus.in_ready), 64'd0);
         checkOutput("out_valid_early", 64'(bus.out_valid), 64'd0);
         @(posedge clk);
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = noise ? 1'($urandom) : 1'b0;
      checkOutput("out_valid_latency", 64'(bus.out_valid), 64'd1);
      checkOutput("out_block", bus.out_block, expOut);
      checkOutput("round_done", 64'(round), 64'd0);
      checkOutput("busy_done", 64'(busy), 64'd1);
      if (!dec) checkOutput("cd_final", 64'(f_cd), 64'(key));
      lastOut = bus.out_block;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         if (noise) begin
            bus.in_valid  = 1'($urandom);
            bus.in_block  = {$urandom, $urandom};
            bus.in_key_cd = {$urandom, $urandom};
         end
         checkOutput("out_block_hold", bus.out_block, expOut);
         checkOutput("out_valid_hold", 64'(bus.out_valid), 64'd1);
         checkOutput("in_ready_hold", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      checkOutput("out_valid_drop", 64'(bus.out_valid), 64'd0);
      checkOutput("in_ready_back", 64'(bus.in_ready), 64'd1);
      checkOutput("busy_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [63:0] pt;
      logic [55:0] key;
      bus.in_valid   = 1'b0;
      bus.in_block   = '0;
      bus.in_key_cd  = '0;
      bus.in_decrypt = 1'b0;
      bus.out_ready  = 1'b0;

      #12;
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_round", 64'(round), 64'd0);
      checkOutput("rst_f_r", 64'(f_r), 64'd0);
      checkOutput("rst_f_cd", 64'(f_cd), 64'd0);
      checkOutput("rst_out_block", bus.out_block, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Single-bit key makes every per-round shift amount directly visible on f_cd.
      applyStimulus(64'h0123456789ABCDEF, 56'h00000010000001, 1'b0, 0, 1'b0);
      applyStimulus(64'h0123456789ABCDEF, 56'h00000010000001, 1'b1, 0, 1'b0);

      zeroF = 1'b1;
      applyStimulus(64'hAAAAAAAA55555555, {$urandom, $urandom}, 1'b0, 1, 1'b0);
      zeroF = 1'b0;

      applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 10, 1'b1);

      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom};
      applyStimulus(pt, key, 1'b0, 0, 1'b0);
      applyStimulus(expOut, key, 1'b1, 2, 1'b0);
      checkOutput("roundtrip", lastOut, pt);

      // Abort mid-round: outputs must clear without any clock edge.
      bus.in_valid  = 1'b1;
      bus.in_block  = {$urandom, $urandom};
      bus.in_key_cd = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("abort_round7", 64'(round), 64'd6);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("abort_round", 64'(round), 64'd0);
      checkOutput("abort_f_r", 64'(f_r), 64'd0);
      checkOutput("abort_f_cd", 64'(f_cd), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("abort_no_pulse", 64'(bus.out_valid), 64'd0);
         checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd1);
      end

      for (int i = 0; i < 6; i++) begin
         applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                       int'($urandom_range(0, 4)), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
